wptr_flag_ctrl: RTL

WPTR_FLAG_CTRL -- requirements
Module: wptr_flag_ctrl

---
 rtl/wptr_flag_ctrl.sv | 99 +++++++++
 1 files changed

// File: rtl/wptr_flag_ctrl.sv
// Write-side pointer and flag controller for an asynchronous FIFO.
// Owns the write pointer and derives full/almost-full/level from a synchronised Gray read pointer.
module wptr_flag_ctrl #(
    parameter int ADDW        = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic            wclk,
    input  logic            wrst_n,
    input  logic            wren,
    input  logic [ADDW:0]   rptr,
    input  logic [ADDW:0]   afull_thr,
    input  logic            ovf_clr,
    output logic [ADDW-1:0] waddr,
    output logic [ADDW:0]   wptr,
    output logic            wfull,
    output logic            wafull,
    output logic [ADDW:0]   wlevel,
    output logic            wovf
);

    logic [ADDW:0] wbin_q,   wbin_d;
    logic [ADDW:0] wptr_q,   wptr_d;
    logic [ADDW:0] wlevel_q, wlevel_d;
    logic          wfull_q,  wfull_d;
    logic          wafull_q, wafull_d;
    logic          wovf_q,   wovf_d;

    logic [ADDW:0] sync_q [SYNC_STAGES];
    logic [ADDW:0] wq_rptr;
    logic [ADDW:0] rbin_s;
    logic          push;
    logic          drop;

    assign wq_rptr = sync_q[SYNC_STAGES-1];

    // Bit i of the binary value is the XOR of all Gray bits from the MSB down to i.
    always_comb begin
        rbin_s = '0;
        for (int i = 0; i <= ADDW; i++) begin
            rbin_s[i] = ^(wq_rptr >> i);
        end
    end

    // NOTE: all next-state terms are pure combinational functions of registered state and
    // inputs; every variable gets a value on every pass so no latch can be inferred.
    always_comb begin
        push     = wren & ~wfull_q;
        drop     = wren &  wfull_q;
        wbin_d   = wbin_q + {{ADDW{1'b0}}, push};
        wptr_d   = (wbin_d >> 1) ^ wbin_d;
        wfull_d  = (wptr_d == {~wq_rptr[ADDW:ADDW-1], wq_rptr[ADDW-2:0]});
        wlevel_d = wbin_d - rbin_s;
        wafull_d = (wlevel_d >= afull_thr);
        wovf_d   = drop | (wovf_q & ~ovf_clr);
    end

    // NOTE: the synchroniser chain is a small register array, not a RAM, so it is reset
    // along with everything else; rptr feeds the first flop directly.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= rptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples the
    // pre-edge value of every other flop.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wlevel_q <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wlevel_q <= wlevel_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wovf_q   <= wovf_d;
        end
    end

    assign waddr  = wbin_q[ADDW-1:0];
    assign wptr   = wptr_q;
    assign wfull  = wfull_q;
    assign wafull = wafull_q;
    assign wlevel = wlevel_q;
    assign wovf   = wovf_q;

endmodule
